// File: rtl/frame_buffer_pingpong.sv
// ---------------------------------------------------------------------------
// frame_buffer_pingpong
//
// Double-buffered frame store between the ray-sweep pixel producer and the
// video output path. The producer writes the back buffer through a
// valid/ready port. The front buffer is read with the raster position,
// nearest-neighbour upscaled by 2^SCALE_LOG2, and expanded to 24-bit RGB.
// The buffers swap once both the producer and the raster have reported the
// last pixel of their frame.
//
// Optional feature macro: FB_CLEAR_EN
//   defined   : a clear engine writes CLEAR_COLOR over the whole back buffer
//               after reset release and after every swap.
//   undefined : no clear engine, clearing_out is tied low.
//
// Handshake: a write transfers on a rising clock edge where wr_valid_in and
// wr_ready_out are both high. wr_ready_out is a function of internal state
// only and never depends on wr_valid_in.
//
// Ports
//   pixel_clk_in         sole clock
//   rst_n_in             asynchronous active-low reset
//   hcount_in/vcount_in  raster position
//   wr_valid_in/wr_ready_out, wr_addr_in, wr_pixel_in  back-buffer write port
//   ray_last_pixel_in    producer finished its frame (1-cycle pulse)
//   video_last_pixel_in  raster finished its frame (1-cycle pulse)
//   rgb_out, rgb_valid_out  pixel output, 3 cycles after the raster position
//   front_sel_out        index of the displayed buffer
//   swap_out             1-cycle pulse on the first cycle after a swap
//   clearing_out         clear engine busy
// ---------------------------------------------------------------------------
module frame_buffer_pingpong #(
  parameter int PIXEL_WIDTH        = 16,
  parameter int SCREEN_WIDTH       = 320,
  parameter int SCREEN_HEIGHT      = 180,
  parameter int SCALE_LOG2         = 2,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter logic [PIXEL_WIDTH-1:0] CLEAR_COLOR = '0,
  localparam int DEPTH  = SCREEN_WIDTH * SCREEN_HEIGHT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   wr_valid_in,
  output logic                   wr_ready_out,
  input  logic [ADDR_W-1:0]      wr_addr_in,
  input  logic [PIXEL_WIDTH-1:0] wr_pixel_in,
  input  logic                   ray_last_pixel_in,
  input  logic                   video_last_pixel_in,
  output logic [23:0]            rgb_out,
  output logic                   rgb_valid_out,
  output logic                   front_sel_out,
  output logic                   swap_out,
  output logic                   clearing_out
);

  typedef enum logic {
    COLLECT = 1'b0,
    SWAP    = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   ray_done_q, ray_done_d;
  logic   video_done_q, video_done_d;
  logic   front_sel_q;
  logic   swap_q;
  logic   init_q;       // low until the first clock edge after reset release
  logic   clear_busy;
  logic [ADDR_W-1:0]      clear_addr;
  logic [PIXEL_WIDTH-1:0] clear_data;

  // ---------------- swap controller ----------------
  // The completing pulse is looked at through the next-flag values so that a
  // pulse at cycle N puts the FSM in SWAP at N+1.
  always_comb begin
    state_d      = state_q;
    ray_done_d   = ray_done_q | ray_last_pixel_in;
    video_done_d = video_done_q | video_last_pixel_in;
    case (state_q)
      COLLECT: begin
        if (ray_done_d && video_done_d && !clear_busy) state_d = SWAP;
      end
      SWAP: begin
        // Flags clear on leaving SWAP; a pulse seen now belongs to the next frame.
        state_d      = COLLECT;
        ray_done_d   = ray_last_pixel_in;
        video_done_d = video_last_pixel_in;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= COLLECT;
      ray_done_q   <= 1'b0;
      video_done_q <= 1'b0;
      front_sel_q  <= 1'b0;
      swap_q       <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ray_done_q   <= ray_done_d;
      video_done_q <= video_done_d;
      swap_q       <= (state_q == SWAP);
      init_q       <= 1'b1;
      if (state_q == SWAP) front_sel_q <= ~front_sel_q;
    end
  end

  assign wr_ready_out  = init_q && (state_q == COLLECT) && !clear_busy;
  assign front_sel_out = front_sel_q;
  assign swap_out      = swap_q;

  // ---------------- clear engine ----------------
`ifdef FB_CLEAR_EN
  logic              clearing_q;
  logic [ADDR_W-1:0] clear_cnt_q;

  // Starts on the first edge after reset release and on the SWAP edge, so
  // clearing is already high in the cycle swap_out is high.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clearing_q  <= 1'b0;
      clear_cnt_q <= '0;
    end else if (!init_q || state_q == SWAP) begin
      clearing_q  <= 1'b1;
      clear_cnt_q <= '0;
    end else if (clearing_q) begin
      if (clear_cnt_q == ADDR_W'(DEPTH - 1)) begin
        clearing_q  <= 1'b0;
        clear_cnt_q <= '0;
      end else begin
        clear_cnt_q <= clear_cnt_q + 1'b1;
      end
    end
  end

  assign clear_busy = clearing_q;
  assign clear_addr = clear_cnt_q;
`else
  assign clear_busy = 1'b0;
  assign clear_addr = '0;
`endif
  assign clear_data   = CLEAR_COLOR;
  assign clearing_out = clear_busy;

  // ---------------- back-buffer write ----------------
  logic                   wr_addr_ok;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_wa;
  logic [PIXEL_WIDTH-1:0] mem_wd;

  // Out-of-range addresses still complete the handshake; only the store is dropped.
  assign wr_addr_ok = (32'(wr_addr_in) < DEPTH);
  assign mem_we     = clear_busy || (wr_valid_in && wr_ready_out && wr_addr_ok);
  assign mem_wa     = clear_busy ? clear_addr : wr_addr_in;
  assign mem_wd     = clear_busy ? clear_data : wr_pixel_in;

  // ---------------- read pipeline ----------------
  logic                   active;
  logic [ADDR_W-1:0]      rd_addr;
  logic [ADDR_W-1:0]      addr_q;
  logic                   sel_q;
  logic                   active_q, active_q2;
  logic [PIXEL_WIDTH-1:0] rd_data_q;
  logic [23:0]            rgb_exp;
  logic [23:0]            rgb_q;
  logic                   rgb_valid_q;

  assign active  = (32'(hcount_in) < FULL_SCREEN_WIDTH) && (32'(vcount_in) < FULL_SCREEN_HEIGHT);
  assign rd_addr = ADDR_W'(hcount_in >> SCALE_LOG2)
                 + ADDR_W'(SCREEN_WIDTH) * ADDR_W'(vcount_in >> SCALE_LOG2);

  // The buffer select travels with the address, so the swap takes effect for
  // addresses registered in the swap_out cycle.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_q      <= '0;
      sel_q       <= 1'b0;
      active_q    <= 1'b0;
      active_q2   <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      addr_q      <= active ? rd_addr : '0;
      sel_q       <= front_sel_q;
      active_q    <= active;
      active_q2   <= active_q;
      rgb_q       <= active_q2 ? rgb_exp : 24'h0;
      rgb_valid_q <= active_q2;
    end
  end

  // Two frame RAMs; the back one (~front_sel) takes writes, sel_q picks the read.
  logic [PIXEL_WIDTH-1:0] mem0 [DEPTH];
  logic [PIXEL_WIDTH-1:0] mem1 [DEPTH];

  always_ff @(posedge pixel_clk_in) begin
    if (mem_we && front_sel_q)  mem0[mem_wa] <= mem_wd;
    if (mem_we && !front_sel_q) mem1[mem_wa] <= mem_wd;
    rd_data_q <= sel_q ? mem1[addr_q] : mem0[addr_q];
  end

  // RGB565 expands by replicating each channel's MSBs into the low bits, so
  // full-scale channels map to 8'hFF. Any other width is taken as RGB888.
  generate
    if (PIXEL_WIDTH == 16) begin : g_rgb565
      assign rgb_exp = {rd_data_q[15:11], rd_data_q[15:13],
                        rd_data_q[10:5],  rd_data_q[10:9],
                        rd_data_q[4:0],   rd_data_q[4:2]};
    end else begin : g_rgb888
      assign rgb_exp = rd_data_q[23:0];
    end
  endgenerate

  assign rgb_out       = rgb_q;
  assign rgb_valid_out = rgb_valid_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_pingpong
//
// Self-checking bench for frame_buffer_pingpong (RGB565, 320x180, x4 scale).
// A bench-side frame model tracks both buffers and the displayed index;
// raster pixels push their expected {valid, rgb} into exp_q and are popped
// when the DUT output is due three cycles later.
// With FB_CLEAR_EN defined the bench covers reset and the clear engine only.
// ---------------------------------------------------------------------------
module tb_frame_buffer_pingpong;

  localparam int DEPTH = 57600;

  logic        pixel_clk_in = 1'b0;
  logic        rst_n_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        wr_valid_in;
  logic        wr_ready_out;
  logic [15:0] wr_addr_in;
  logic [15:0] wr_pixel_in;
  logic        ray_last_pixel_in;
  logic        video_last_pixel_in;
  logic [23:0] rgb_out;
  logic        rgb_valid_out;
  logic        front_sel_out;
  logic        swap_out;
  logic        clearing_out;

  frame_buffer_pingpong dut (
    .pixel_clk_in        (pixel_clk_in),
    .rst_n_in            (rst_n_in),
    .hcount_in           (hcount_in),
    .vcount_in           (vcount_in),
    .wr_valid_in         (wr_valid_in),
    .wr_ready_out        (wr_ready_out),
    .wr_addr_in          (wr_addr_in),
    .wr_pixel_in         (wr_pixel_in),
    .ray_last_pixel_in   (ray_last_pixel_in),
    .video_last_pixel_in (video_last_pixel_in),
    .rgb_out             (rgb_out),
    .rgb_valid_out       (rgb_valid_out),
    .front_sel_out       (front_sel_out),
    .swap_out            (swap_out),
    .clearing_out        (clearing_out)
  );

  // ---------------- clock ----------------
  always #5 pixel_clk_in = ~pixel_clk_in;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model and scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] mdl [2][DEPTH];
  logic        mdl_front = 1'b0;
  logic [24:0] exp_q[$];
  int          hq[$];
  int          vq[$];
  int          wa_q[$];
  logic [15:0] wd_q[$];

  function automatic logic [23:0] expand565(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic tick();
    @(posedge pixel_clk_in);
    #1;
  endtask

  // ---------------- drivers ----------------
  // Drives wa_q/wd_q back to back; each word transfers on the edge after a
  // negedge where ready was seen high.
  task automatic write_burst(input string name);
    int w;
    foreach (wa_q[i]) begin
      tick();
      wr_valid_in = 1'b1;
      wr_addr_in  = 16'(wa_q[i]);
      wr_pixel_in = wd_q[i];
      w = 0;
      @(negedge pixel_clk_in);
      while (!wr_ready_out && w < 50) begin
        @(negedge pixel_clk_in);
        w++;
      end
      if (!wr_ready_out) begin
        n_checks++;
        $display("FAIL %s: write handshake timeout at addr %0d, ready=%0b want 1", name, wa_q[i], wr_ready_out);
        break;
      end
      if (wa_q[i] < DEPTH) mdl[!mdl_front][wa_q[i]] = wd_q[i];
    end
    tick();
    wr_valid_in = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  // Plays hq/vq as raster positions, one per cycle, and checks each pixel
  // three cycles later against the model.
  task automatic run_raster(input string name);
    int          n, a;
    bit          act;
    logic [24:0] e;
    n = hq.size();
    for (int i = 0; i < n + 3; i++) begin
      tick();
      if (i < n) begin
        hcount_in = 11'(hq[i]);
        vcount_in = 10'(vq[i]);
        act = (hq[i] < 1280) && (vq[i] < 720);
        a   = (hq[i] >> 2) + 320 * (vq[i] >> 2);
        if (act) exp_q.push_back({1'b1, expand565(mdl[mdl_front][a])});
        else     exp_q.push_back(25'd0);
      end else begin
        hcount_in = 11'd1400;
        vcount_in = 10'd0;
      end
      @(negedge pixel_clk_in);
      if (i >= 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({rgb_valid_out, rgb_out} !== e)
          $display("FAIL %s pixel %0d (h=%0d v=%0d): got valid=%0b rgb=%06h, want valid=%0b rgb=%06h",
                   name, i - 3, hq[i - 3], vq[i - 3], rgb_valid_out, rgb_out, e[24], e[23:0]);
        else n_pass++;
      end
    end
    hq.delete();
    vq.delete();
  endtask

  // Called in the cycle where the completing pulse(s) are being driven.
  task automatic expect_swap(input string name);
    @(negedge pixel_clk_in);
    n_checks++;
    if (swap_out !== 1'b0 || wr_ready_out !== 1'b1)
      $display("FAIL %s pulse cycle: got swap=%0b ready=%0b, want swap=0 ready=1", name, swap_out, wr_ready_out);
    else n_pass++;
    tick();
    ray_last_pixel_in   = 1'b0;
    video_last_pixel_in = 1'b0;
    @(negedge pixel_clk_in);
    n_checks++;
    if (wr_ready_out !== 1'b0 || swap_out !== 1'b0 || front_sel_out !== mdl_front)
      $display("FAIL %s swap cycle: got ready=%0b swap=%0b front=%0b, want ready=0 swap=0 front=%0b",
               name, wr_ready_out, swap_out, front_sel_out, mdl_front);
    else n_pass++;
    tick();
    @(negedge pixel_clk_in);
    mdl_front = !mdl_front;
    n_checks++;
    if (swap_out !== 1'b1 || front_sel_out !== mdl_front || wr_ready_out !== 1'b1)
      $display("FAIL %s swap_out cycle: got swap=%0b front=%0b ready=%0b, want swap=1 front=%0b ready=1",
               name, swap_out, front_sel_out, wr_ready_out, mdl_front);
    else n_pass++;
    tick();
    @(negedge pixel_clk_in);
    n_checks++;
    if (swap_out !== 1'b0)
      $display("FAIL %s swap_out width: got swap=%0b one cycle later, want 0", name, swap_out);
    else n_pass++;
  endtask

  task automatic no_swap_window(input int cycles, input string name);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      @(negedge pixel_clk_in);
      if (swap_out !== 1'b0 || wr_ready_out !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0 || front_sel_out !== mdl_front)
      $display("FAIL %s: got %0d swap/stall cycles, front=%0b, want 0 cycles, front=%0b", name, bad, front_sel_out, mdl_front);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n_in = 1'b1;
    #1 rst_n_in = 1'b0;
    repeat (3) @(posedge pixel_clk_in);
    @(negedge pixel_clk_in);
    n_checks++;
    if (front_sel_out !== 1'b0 || swap_out !== 1'b0 || wr_ready_out !== 1'b0 ||
        rgb_out !== 24'h0 || rgb_valid_out !== 1'b0 || clearing_out !== 1'b0)
      $display("FAIL reset_values: got front=%0b swap=%0b ready=%0b rgb=%06h valid=%0b clr=%0b, want all 0",
               front_sel_out, swap_out, wr_ready_out, rgb_out, rgb_valid_out, clearing_out);
    else n_pass++;
    tick();
    rst_n_in = 1'b1;
    tick();
    @(negedge pixel_clk_in);
    n_checks++;
`ifdef FB_CLEAR_EN
    if (wr_ready_out !== 1'b0 || clearing_out !== 1'b1)
      $display("FAIL after_release: got ready=%0b clearing=%0b, want ready=0 clearing=1", wr_ready_out, clearing_out);
    else n_pass++;
`else
    if (wr_ready_out !== 1'b1 || clearing_out !== 1'b0)
      $display("FAIL after_release: got ready=%0b clearing=%0b, want ready=1 clearing=0", wr_ready_out, clearing_out);
    else n_pass++;
`endif
  endtask

  // Writes buffer 1, swaps with both pulses in one cycle, then reads it back.
  task automatic test_color_latency();
    wa_q = '{0, 1, 57599, 57600};
    wd_q = '{16'hFFFF, 16'hF800, 16'h07E0, 16'h1234};
    write_burst("preload");
    tick();
    ray_last_pixel_in   = 1'b1;
    video_last_pixel_in = 1'b1;
    expect_swap("swap_same_cycle");
    for (int h = 0; h < 8; h++) begin
      hq.push_back(h);
      vq.push_back(0);
    end
    hq.push_back(1279); vq.push_back(719);
    hq.push_back(1280); vq.push_back(0);
    hq.push_back(0);    vq.push_back(720);
    hq.push_back(1280); vq.push_back(720);
    hq.push_back(1500); vq.push_back(5);
    for (int i = 0; i < 6; i++) begin
      hq.push_back($urandom_range(0, 7));
      vq.push_back($urandom_range(0, 3));
    end
    run_raster("color_latency");
  endtask

  task automatic test_swap_ordered();
    tick(); ray_last_pixel_in = 1'b1;
    tick(); ray_last_pixel_in = 1'b0;
    repeat (5) tick();
    ray_last_pixel_in = 1'b1;
    tick(); ray_last_pixel_in = 1'b0;
    no_swap_window(100, "no_swap_before_video");
    tick();
    video_last_pixel_in = 1'b1;
    expect_swap("swap_ordered");
  endtask

  task automatic test_pulse_during_swap();
    tick();
    ray_last_pixel_in   = 1'b1;
    video_last_pixel_in = 1'b1;
    @(negedge pixel_clk_in);
    tick();
    ray_last_pixel_in   = 1'b0;
    video_last_pixel_in = 1'b1;   // lands in the SWAP cycle
    @(negedge pixel_clk_in);
    n_checks++;
    if (wr_ready_out !== 1'b0)
      $display("FAIL pulse_in_swap stall: got ready=%0b in swap cycle, want 0", wr_ready_out);
    else n_pass++;
    tick();
    video_last_pixel_in = 1'b0;
    @(negedge pixel_clk_in);
    mdl_front = !mdl_front;
    n_checks++;
    if (swap_out !== 1'b1 || front_sel_out !== mdl_front)
      $display("FAIL pulse_in_swap first: got swap=%0b front=%0b, want swap=1 front=%0b", swap_out, front_sel_out, mdl_front);
    else n_pass++;
    no_swap_window(9, "video_credit_only");
    tick();
    ray_last_pixel_in = 1'b1;
    expect_swap("swap_after_credit");
  endtask

  // Back-to-back random writes, swap, then sample every written location.
  task automatic test_back_to_back();
    int addrs[$];
    int a;
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(2, 57598);
      addrs.push_back(a);
      wa_q.push_back(a);
      wd_q.push_back(16'($urandom_range(0, 65535)));
    end
    write_burst("burst");
    tick();
    video_last_pixel_in = 1'b1;
    tick();
    video_last_pixel_in = 1'b0;
    ray_last_pixel_in   = 1'b1;
    expect_swap("swap_burst");
    foreach (addrs[i]) begin
      hq.push_back(((addrs[i] % 320) << 2) + $urandom_range(0, 3));
      vq.push_back(((addrs[i] / 320) << 2) + $urandom_range(0, 3));
    end
    run_raster("burst_readback");
  endtask

  task automatic test_reset_midframe();
    hq = '{0, 2, 3, 1};
    vq = '{0, 1, 0, 3};
    run_raster("pre_reset_read");
    tick(); ray_last_pixel_in = 1'b1;
    tick(); ray_last_pixel_in = 1'b0;
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    repeat (4) tick();
    rst_n_in = 1'b0;
    #2;
    n_checks++;
    if (front_sel_out !== 1'b0 || swap_out !== 1'b0 || wr_ready_out !== 1'b0 ||
        rgb_out !== 24'h0 || rgb_valid_out !== 1'b0 || clearing_out !== 1'b0)
      $display("FAIL midframe_reset: got front=%0b swap=%0b ready=%0b rgb=%06h valid=%0b clr=%0b, want all 0",
               front_sel_out, swap_out, wr_ready_out, rgb_out, rgb_valid_out, clearing_out);
    else n_pass++;
    mdl_front = 1'b0;
    hcount_in = 11'd1400;
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();
    tick();
    video_last_pixel_in = 1'b1;
    tick();
    video_last_pixel_in = 1'b0;
    no_swap_window(20, "ray_flag_cleared_by_reset");
    tick();
    ray_last_pixel_in = 1'b1;
    expect_swap("swap_after_reset");
    hq = '{0, 5, 1279};
    vq = '{0, 0, 719};
    run_raster("post_reset_read");
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int cnt = 1;
    int ready_bad = 0;
    int swaps = 0;
    int w = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      tick();
      ray_last_pixel_in   = (i == 100);
      video_last_pixel_in = (i == 200);
      @(negedge pixel_clk_in);
      if (swap_out) swaps++;
      if (!clearing_out) break;
      cnt++;
      if (wr_ready_out) ready_bad++;
    end
    n_checks++;
    if (cnt != DEPTH || ready_bad != 0 || swaps != 0)
      $display("FAIL clear_length: got %0d clear cycles, %0d ready, %0d swaps, want %0d, 0, 0", cnt, ready_bad, swaps, DEPTH);
    else n_pass++;
    while (!swap_out && w < 10) begin
      tick();
      @(negedge pixel_clk_in);
      w++;
    end
    n_checks++;
    if (swap_out !== 1'b1 || front_sel_out !== 1'b1 || clearing_out !== 1'b1)
      $display("FAIL deferred_swap: got swap=%0b front=%0b clearing=%0b, want 1 1 1", swap_out, front_sel_out, clearing_out);
    else n_pass++;
    mdl_front = 1'b1;
    mdl[1][0]     = 16'h0000;
    mdl[1][57599] = 16'h0000;
    hq = '{0, 1279};
    vq = '{0, 719};
    run_raster("cleared_readback");
  endtask
`endif

  // ---------------- sequence ----------------
  initial begin
    hcount_in           = 11'd1400;
    vcount_in           = 10'd0;
    wr_valid_in         = 1'b0;
    wr_addr_in          = 16'd0;
    wr_pixel_in         = 16'd0;
    ray_last_pixel_in   = 1'b0;
    video_last_pixel_in = 1'b0;
    test_reset();
`ifdef FB_CLEAR_EN
    test_clear();
`else
    test_color_latency();
    test_swap_ordered();
    test_pulse_during_swap();
    test_back_to_back();
    test_reset_midframe();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
